conv_row_scheduler: RTL

Row-level sequencer for `conv_top`. It reads padded input rows from a row memory and maintains a three-row sliding window. It drives the window onto `conv_top`'s `image0/1/2`, pulses `image_start`, and waits for `output_add_done_o`. It then writes each result row to an output memory, so one frame start yields all H output rows with no testbench-style manual pulsing.

---
 rtl/conv_row_scheduler_if.sv | 40 ++++
 rtl/conv_row_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/conv_row_scheduler_if.sv
// conv_row_scheduler_if: row-memory read port, conv_top window/launch bus and
// output-memory write port of the row scheduler, bundled for one connection.
interface conv_row_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int D          = 4,
    parameter int W          = 12,
    parameter int AW         = 4,
    parameter int OUT_ROW_W  = 1536
);
    localparam int RW = D * DATA_WIDTH * (W + 2);

    logic                 row_rd_en_o;
    logic [AW-1:0]        row_rd_addr_o;
    logic [RW-1:0]        row_rd_data_i;
    logic [RW-1:0]        conv_row0_o;
    logic [RW-1:0]        conv_row1_o;
    logic [RW-1:0]        conv_row2_o;
    logic                 conv_start_o;
    logic                 conv_done_i;
    logic [OUT_ROW_W-1:0] conv_result_i;
    logic                 out_wr_en_o;
    logic [AW-1:0]        out_wr_addr_o;
    logic [OUT_ROW_W-1:0] out_wr_data_o;

    modport master (
        output row_rd_en_o, row_rd_addr_o,
        input  row_rd_data_i,
        output conv_row0_o, conv_row1_o, conv_row2_o, conv_start_o,
        input  conv_done_i, conv_result_i,
        output out_wr_en_o, out_wr_addr_o, out_wr_data_o
    );

    modport slave (
        input  row_rd_en_o, row_rd_addr_o,
        output row_rd_data_i,
        input  conv_row0_o, conv_row1_o, conv_row2_o, conv_start_o,
        output conv_done_i, conv_result_i,
        input  out_wr_en_o, out_wr_addr_o, out_wr_data_o
    );
endinterface

// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: three-row sliding window sequencer driving conv_top.
// Define CONV_ROW_ZERO_PAD_EN to synthesize the top/bottom zero rows on chip.
module conv_row_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int D          = 4,
    parameter int W          = 12,
    parameter int H          = 12,
    parameter int AW         = 4,
    parameter int OUT_ROW_W  = 1536
) (
    input  logic                 clk,
    input  logic                 rstn_i,
    input  logic                 frame_start_i,
    output logic                 busy_o,
    output logic                 frame_done_o,
    conv_row_scheduler_if.master bus
);

    localparam int RW = D * DATA_WIDTH * (W + 2);

`ifdef CONV_ROW_ZERO_PAD_EN
    localparam logic [1:0]    PRIME_RDS = 2'd2;
    localparam logic [AW-1:0] FETCH_OFS = AW'(2);
    localparam bit            ZPAD      = 1'b1;
`else
    localparam logic [1:0]    PRIME_RDS = 2'd3;
    localparam logic [AW-1:0] FETCH_OFS = AW'(3);
    localparam bit            ZPAD      = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        LAUNCH,
        WAIT,
        STORE,
        FETCH,
        FETCH_SH,
        DONE
    } state_e;

    state_e               state_q;
    logic [AW-1:0]        r_q;
    logic [1:0]           cnt_q;
    logic                 fetch_vld_q;
    logic [RW-1:0]        row0_q;
    logic [RW-1:0]        row1_q;
    logic [RW-1:0]        row2_q;
    logic                 rd_en_q;
    logic [AW-1:0]        rd_addr_q;
    logic                 start_q;
    logic                 wr_en_q;
    logic [AW-1:0]        wr_addr_q;
    logic [OUT_ROW_W-1:0] res_q;
    logic                 busy_q;
    logic                 done_q;

    logic last_row;
    logic skip_rd;

    assign last_row = (r_q == AW'(H - 1));
    // Bottom pad row of the last window is zero, not a memory word.
    assign skip_rd  = ZPAD && (r_q == AW'(H - 2));

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            r_q         <= '0;
            cnt_q       <= '0;
            fetch_vld_q <= 1'b0;
            row0_q      <= '0;
            row1_q      <= '0;
            row2_q      <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            start_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            res_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_start_i) begin
                        state_q   <= PRIME;
                        r_q       <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                PRIME: begin
                    // cnt_q counts PRIME cycles; data lags the read by one.
                    cnt_q     <= cnt_q + 2'd1;
                    rd_en_q   <= (cnt_q < PRIME_RDS - 2'd1);
                    rd_addr_q <= AW'(cnt_q + 2'd1);
                    if (cnt_q != 2'd0) begin
                        if (ZPAD && cnt_q == 2'd1) begin
                            row0_q <= '0;
                            row1_q <= '0;
                        end else begin
                            row0_q <= row1_q;
                            row1_q <= row2_q;
                        end
                        row2_q <= bus.row_rd_data_i;
                    end
                    if (cnt_q == PRIME_RDS) begin
                        state_q <= LAUNCH;
                        start_q <= 1'b1;
                    end
                end
                LAUNCH: begin
                    start_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.conv_done_i) begin
                        res_q     <= bus.conv_result_i;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= r_q;
                        state_q   <= STORE;
                    end
                end
                STORE: begin
                    wr_en_q <= 1'b0;
                    if (last_row) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= FETCH;
                        rd_en_q     <= !skip_rd;
                        rd_addr_q   <= r_q + FETCH_OFS;
                        fetch_vld_q <= !skip_rd;
                    end
                end
                FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= FETCH_SH;
                end
                FETCH_SH: begin
                    row0_q  <= row1_q;
                    row1_q  <= row2_q;
                    row2_q  <= fetch_vld_q ? bus.row_rd_data_i : '0;
                    r_q     <= r_q + AW'(1);
                    start_q <= 1'b1;
                    state_q <= LAUNCH;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o            = busy_q;
    assign frame_done_o      = done_q;
    assign bus.row_rd_en_o   = rd_en_q;
    assign bus.row_rd_addr_o = rd_addr_q;
    assign bus.conv_row0_o   = row0_q;
    assign bus.conv_row1_o   = row1_q;
    assign bus.conv_row2_o   = row2_q;
    assign bus.conv_start_o  = start_q;
    assign bus.out_wr_en_o   = wr_en_q;
    assign bus.out_wr_addr_o = wr_addr_q;
    assign bus.out_wr_data_o = res_q;

endmodule
